// File: rtl/ola_output.sv
// Overlap-add output stage: drains 64-sample IFFT frames from FIFO5, overlap-adds
// them with a 32-sample hop into ping-pong buffers, and plays them out at the DAC rate.
module ola_output #(
  parameter int unsigned DW  = 16,
  parameter int unsigned N   = 64,
  parameter int unsigned HOP = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          empty5,
  input  logic [DW-1:0] q5,
  output logic          rdreq5,
  input  logic          sample_tick,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  output logic          underrun,
  output logic          busy
);

  localparam int unsigned AW = $clog2(HOP);
  localparam int unsigned KW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] req_cnt;
  logic [KW-1:0] k;
  logic          cap_vld;
  logic          last_cap;
  logic          fill_sel;
  logic          play_sel;
  logic [1:0]    ready;
  logic [1:0]    ready_nxt;
  logic [AW-1:0] p;
  logic          primed;
  logic          play_hit;
  logic          play_wrap;

  logic [DW-1:0] tail    [HOP];
  logic [DW-1:0] hop_buf [2][HOP];

  logic [DW-1:0] tail_rd;
  logic [DW:0]   sum_c;
  logic [DW-1:0] sat_c;

  assign last_cap = cap_vld && (k == KW'(N - 1));

  // Loader state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Loader next-state and FIFO5 read request
  always_comb begin
    state_nxt = state;
    rdreq5    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT;
      end
      WAIT: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (!ready[fill_sel] && !empty5) begin
          state_nxt = READ;
        end
      end
      READ: begin
        rdreq5 = (req_cnt < CW'(N)) && !empty5;
        if (last_cap) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Overlap-add of the captured word with the stored tail, saturated to DW bits
  always_comb begin
    tail_rd = tail[AW'(k)];
    sum_c   = {q5[DW-1], q5} + {tail_rd[DW-1], tail_rd};
    if (sum_c[DW] != sum_c[DW-1]) begin
      sat_c = sum_c[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat_c = sum_c[DW-1:0];
    end
  end

  // Request/capture counters, tail storage and fill-side bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_cnt  <= '0;
      k        <= '0;
      cap_vld  <= 1'b0;
      fill_sel <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < int'(HOP); i++) begin
        tail[i] <= '0;
      end
    end else begin
      cap_vld <= rdreq5;
      busy    <= (state_nxt != IDLE);
      if (rdreq5) begin
        req_cnt <= req_cnt + CW'(1);
      end
      if (cap_vld) begin
        k <= last_cap ? '0 : k + KW'(1);
        if (k >= KW'(HOP)) begin
          tail[AW'(k - KW'(HOP))] <= q5;
        end
      end
      if (state == DONE) begin
        req_cnt  <= '0;
        fill_sel <= ~fill_sel;
      end
    end
  end

  // Hop buffers hold only data; validity is tracked by the ready bits
  always_ff @(posedge clock) begin
    if (cap_vld && (k < KW'(HOP))) begin
      hop_buf[fill_sel][AW'(k)] <= sat_c;
    end
  end

  assign play_hit  = sample_tick && ready[play_sel];
  assign play_wrap = play_hit && (p == AW'(HOP - 1));

  // Ready bits: the player clear and the loader set touch different buffers
  always_comb begin
    ready_nxt = ready;
    if (play_wrap) ready_nxt[play_sel] = 1'b0;
    if (state == DONE) ready_nxt[fill_sel] = 1'b1;
  end

  // Player: one sample per tick, zero-fill when the current buffer is not ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready     <= 2'b00;
      play_sel  <= 1'b0;
      p         <= '0;
      primed    <= 1'b0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      ready     <= ready_nxt;
      dac_valid <= sample_tick;
      if (play_hit) begin
        dac_data <= hop_buf[play_sel][p];
        if (play_wrap) begin
          play_sel <= ~play_sel;
          p        <= '0;
          primed   <= 1'b1;
        end else begin
          p <= p + AW'(1);
        end
      end else if (sample_tick) begin
        dac_data <= '0;
        if (primed) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ola_output.sv
// Scoreboard bench for ola_output: a FIFO5 model feeds frames, expected hop samples
// are queued when a frame is pushed and compared as the DAC produces them.
module tb_ola_output;

  localparam int unsigned DW       = 16;
  localparam int unsigned N        = 64;
  localparam int unsigned HOP      = 32;
  localparam int unsigned TICK_GAP = 134;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          empty5 = 1'b1;
  logic [DW-1:0] q5 = '0;
  logic          rdreq5;
  logic          sample_tick;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          underrun;
  logic          busy;

  logic [DW-1:0] src_mem [2048];
  int            wptr = 0;
  int            rptr = 0;
  int            rd_pulses = 0;
  int            rd_empty_hits = 0;
  int            src_under = 0;
  int            cyc = 0;
  bit            stall_en = 1'b0;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [DW-1:0] exp_q [$];
  int            tb_tail [HOP];
  int            frm [N];

  ola_output #(.DW(DW), .N(N), .HOP(HOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .empty5      (empty5),
    .q5          (q5),
    .rdreq5      (rdreq5),
    .sample_tick (sample_tick),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // FIFO5 model: normal mode, data appears the cycle after the request
  always @(posedge clock) begin
    if (rdreq5 === 1'b1) begin
      rd_pulses++;
      if (empty5) rd_empty_hits++;
      if (rptr < wptr) begin
        q5 <= src_mem[rptr];
        rptr++;
      end else begin
        src_under++;
      end
    end
  end

  always @(negedge clock) begin
    cyc++;
    empty5 <= (rptr >= wptr) || (stall_en && ((cyc / 3) % 2 == 1));
  end

  function automatic logic [DW-1:0] sat16(input int a);
    if (a > 32767) return 16'h7fff;
    if (a < -32768) return 16'h8000;
    return 16'(a);
  endfunction

  task automatic push_frame();
    for (int i = 0; i < int'(HOP); i++) begin
      exp_q.push_back(sat16(frm[i] + tb_tail[i]));
      tb_tail[i] = frm[HOP + i];
    end
    for (int i = 0; i < int'(N); i++) begin
      src_mem[wptr] = 16'(frm[i]);
      wptr++;
    end
  endtask

  task automatic clear_model();
    wptr = rptr;
    exp_q.delete();
    for (int i = 0; i < int'(HOP); i++) tb_tail[i] = 0;
  endtask

  task automatic reset_dut();
    reset       = 1'b1;
    start       = 1'b0;
    sample_tick = 1'b0;
    stall_en    = 1'b0;
    repeat (3) @(negedge clock);
    clear_model();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_tick(output logic [DW-1:0] d, output logic v, output logic u);
    @(negedge clock);
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    d = dac_data;
    v = dac_valid;
    u = underrun;
    repeat (TICK_GAP) @(negedge clock);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    start       = 1'b0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({rdreq5, dac_valid, underrun, busy, dac_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdreq5=%b valid=%b underrun=%b busy=%b data=%h, want all 0",
               rdreq5, dac_valid, underrun, busy, dac_data);
    end
    clear_model();
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_wait: got %b, want 1", busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_idle: got %b, want 0", busy);
    end
  endtask

  task automatic test_pass_through_overlap();
    logic [DW-1:0] d, e;
    logic v, u;
    reset_dut();
    start = 1'b1;
    for (int i = 0; i < int'(N); i++) frm[i] = 100 + i;
    push_frame();
    repeat (100) @(negedge clock);
    for (int i = 0; i < int'(HOP); i++) begin
      do_tick(d, v, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      tests_run++;
      if ({v, u, d} !== {1'b1, 1'b0, e} || d !== 16'(100 + i)) begin
        tests_failed++;
        $display("FAIL pass_through[%0d]: got valid=%b underrun=%b data=%0d, want 1/0/%0d",
                 i, v, u, $signed(d), 100 + i);
      end
    end
    for (int i = 0; i < int'(N); i++) frm[i] = 10;
    push_frame();
    repeat (100) @(negedge clock);
    for (int i = 0; i < int'(HOP); i++) begin
      do_tick(d, v, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      tests_run++;
      if ({v, u, d} !== {1'b1, 1'b0, e} || d !== 16'(142 + i)) begin
        tests_failed++;
        $display("FAIL overlap_add[%0d]: got valid=%b underrun=%b data=%0d, want 1/0/%0d",
                 i, v, u, $signed(d), 142 + i);
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d, e;
    logic v, u;
    reset_dut();
    start = 1'b1;
    for (int i = 0; i < int'(N); i++) frm[i] = (i < int'(HOP)) ? 0 : 32000;
    push_frame();
    for (int i = 0; i < int'(N); i++) frm[i] = (i < int'(HOP)) ? 1000 : -32000;
    push_frame();
    for (int i = 0; i < int'(N); i++) frm[i] = (i < int'(HOP)) ? -1000 : 0;
    push_frame();
    repeat (200) @(negedge clock);
    for (int i = 0; i < 3 * int'(HOP); i++) begin
      do_tick(d, v, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      tests_run++;
      if ({v, d} !== {1'b1, e}) begin
        tests_failed++;
        $display("FAIL saturation[%0d]: got valid=%b data=%0d, want 1/%0d",
                 i, v, $signed(d), $signed(e));
      end
      if (i == int'(HOP) || i == 2 * int'(HOP)) begin
        e = (i == int'(HOP)) ? 16'h7fff : 16'h8000;
        tests_run++;
        if (d !== e) begin
          tests_failed++;
          $display("FAIL saturation_limit[%0d]: got %0d, want %0d", i, $signed(d), $signed(e));
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] d, e;
    logic v, u;
    reset_dut();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_tick(d, v, u);
      tests_run++;
      if ({v, u, d} !== {1'b1, 1'b0, 16'h0000}) begin
        tests_failed++;
        $display("FAIL unprimed_tick[%0d]: got valid=%b underrun=%b data=%0d, want 1/0/0",
                 i, v, u, $signed(d));
      end
    end
    for (int i = 0; i < int'(N); i++) frm[i] = i * 3 - 90;
    push_frame();
    for (int i = 0; i < int'(N); i++) frm[i] = 500 - i;
    push_frame();
    repeat (200) @(negedge clock);
    for (int i = 0; i < 70; i++) begin
      do_tick(d, v, u);
      if (i < 2 * int'(HOP)) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      end else begin
        e = '0;
      end
      tests_run++;
      if ({v, u, d} !== {1'b1, (i >= 2 * int'(HOP)), e}) begin
        tests_failed++;
        $display("FAIL underrun_tick[%0d]: got valid=%b underrun=%b data=%0d, want 1/%0d/%0d",
                 i, v, u, $signed(d), (i >= 2 * int'(HOP)), $signed(e));
      end
    end
  endtask

  task automatic test_stalled_fifo();
    logic [DW-1:0] d, e;
    logic v, u;
    int p0, h0;
    reset_dut();
    stall_en = 1'b1;
    p0 = rd_pulses;
    h0 = rd_empty_hits;
    start = 1'b1;
    for (int i = 0; i < int'(N); i++) frm[i] = int'($signed(16'($urandom())));
    push_frame();
    for (int i = 0; i < int'(N); i++) frm[i] = int'($signed(16'($urandom())));
    push_frame();
    for (int c = 0; c < 2000 && rptr < wptr; c++) @(negedge clock);
    repeat (20) @(negedge clock);
    tests_run++;
    if (rd_pulses - p0 != 2 * int'(N)) begin
      tests_failed++;
      $display("FAIL stall_req_count: got %0d, want %0d", rd_pulses - p0, 2 * N);
    end
    tests_run++;
    if (rd_empty_hits - h0 != 0) begin
      tests_failed++;
      $display("FAIL stall_req_while_empty: got %0d, want 0", rd_empty_hits - h0);
    end
    for (int i = 0; i < 2 * int'(HOP); i++) begin
      do_tick(d, v, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      tests_run++;
      if ({v, u, d} !== {1'b1, 1'b0, e}) begin
        tests_failed++;
        $display("FAIL stall_data[%0d]: got valid=%b underrun=%b data=%0d, want 1/0/%0d",
                 i, v, u, $signed(d), $signed(e));
      end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] d, e;
    logic v, u;
    int p0;
    bit hit;
    reset_dut();
    start = 1'b1;
    for (int i = 0; i < int'(N); i++) frm[i] = 200 + i;
    push_frame();
    p0  = rd_pulses;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clock);
      #1;
      hit = (rd_pulses - p0 >= 20);
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL midread_timeout: got %0d requests, want 20", rd_pulses - p0);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({rdreq5, dac_valid, underrun, busy, dac_data} !== '0) begin
      tests_failed++;
      $display("FAIL midread_reset_outputs: got rdreq5=%b valid=%b underrun=%b busy=%b data=%h, want all 0",
               rdreq5, dac_valid, underrun, busy, dac_data);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    clear_model();
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    do_tick(d, v, u);
    tests_run++;
    if ({v, u, d} !== {1'b1, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL midread_not_ready: got valid=%b underrun=%b data=%0d, want 1/0/0",
               v, u, $signed(d));
    end
    for (int i = 0; i < int'(N); i++) frm[i] = 100 + i;
    push_frame();
    repeat (100) @(negedge clock);
    for (int i = 0; i < int'(HOP); i++) begin
      do_tick(d, v, u);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hdead;
      tests_run++;
      if ({v, u, d} !== {1'b1, 1'b0, e} || d !== 16'(100 + i)) begin
        tests_failed++;
        $display("FAIL midread_replay[%0d]: got valid=%b underrun=%b data=%0d, want 1/0/%0d",
                 i, v, u, $signed(d), 100 + i);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < int'(HOP); i++) tb_tail[i] = 0;
    test_reset();
    test_pass_through_overlap();
    test_saturation();
    test_underrun();
    test_stalled_fifo();
    test_reset_mid_read();
    tests_run++;
    if (src_under != 0) begin
      tests_failed++;
      $display("FAIL fifo_overread: got %0d reads of an empty FIFO5, want 0", src_under);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
